// File: rtl/ppu_pixel_out.sv
// Final PPU pixel stage: takes 2bpp tile rows, drops fine-scroll pixels,
// maps indices through BGP and emits 160x144 frames with hs/vs pulses.
module ppu_pixel_out #(
  parameter int unsigned LINE_PIXELS = 160,
  parameter int unsigned FRAME_LINES = 144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic [2:0] scx_fine,
  input  logic [7:0] bgp,
  input  logic [7:0] tile_lo,
  input  logic [7:0] tile_hi,
  input  logic       tile_valid,
  output logic       tile_ready,
  output logic       ppu_vs,
  output logic       ppu_hs,
  output logic       ppu_de,
  output logic [1:0] ppu_color,
  output logic       busy,
  output logic [7:0] ly
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISCARD,
    S_ACTIVE,
    S_ENDLINE
  } state_t;

  state_t     state, state_d;
  logic [7:0] sh_lo, sh_hi, lo_d, hi_d;
  logic [3:0] cnt, cnt_d;
  logic [7:0] px, px_d;
  logic [2:0] disc, disc_d;
  logic [7:0] ly_d;
  logic       vs_d, hs_d, de_d;
  logic [1:0] color_d;
  logic [1:0] idx;

  logic discarding, deq, emit, last, load;

  assign busy       = (state == S_DISCARD) || (state == S_ACTIVE);
  assign discarding = (state == S_DISCARD) && (disc != 3'd0);
  assign deq        = busy && (cnt != 4'd0);
  assign emit       = deq && !discarding;
  assign last       = emit && (px == 8'(LINE_PIXELS - 1));
  // A tile taken alongside the final pixel, or while a frame restart
  // flushes the register, would be thrown away, so no offer is accepted then.
  assign tile_ready = busy && !frame_start && !last &&
                      ((cnt == 4'd0) || ((cnt == 4'd1) && deq));
  assign load       = tile_ready && tile_valid;
  assign idx        = {sh_hi[7], sh_lo[7]};

  always_comb begin
    state_d = state;
    lo_d    = sh_lo;
    hi_d    = sh_hi;
    cnt_d   = cnt;
    px_d    = px;
    disc_d  = disc;
    ly_d    = ly;
    vs_d    = 1'b0;
    hs_d    = 1'b0;
    de_d    = 1'b0;
    color_d = ppu_color;

    unique case (state)
      S_IDLE: begin
        if (line_start && (ly < 8'(FRAME_LINES))) begin
          state_d = S_DISCARD;
          disc_d  = scx_fine;
          px_d    = '0;
        end
      end
      S_DISCARD, S_ACTIVE: begin
        if (deq) begin
          lo_d  = {sh_lo[6:0], 1'b0};
          hi_d  = {sh_hi[6:0], 1'b0};
          cnt_d = cnt - 4'd1;
          if (discarding) begin
            disc_d = disc - 3'd1;
          end else begin
            de_d    = 1'b1;
            color_d = bgp[{idx, 1'b1} -: 2];
            px_d    = px + 8'd1;
          end
        end
        if (load) begin
          lo_d  = tile_lo;
          hi_d  = tile_hi;
          cnt_d = 4'd8;
        end
        if ((state == S_DISCARD) && !discarding) state_d = S_ACTIVE;
        if (last) state_d = S_ENDLINE;
      end
      S_ENDLINE: begin
        hs_d    = 1'b1;
        cnt_d   = '0;
        ly_d    = ly + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Frame restart overrides everything, but a coincident line_start
    // still opens line 0.
    if (frame_start) begin
      vs_d    = 1'b1;
      hs_d    = 1'b0;
      de_d    = 1'b0;
      ly_d    = '0;
      cnt_d   = '0;
      px_d    = '0;
      state_d = S_IDLE;
      if (line_start) begin
        state_d = S_DISCARD;
        disc_d  = scx_fine;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sh_lo     <= '0;
      sh_hi     <= '0;
      cnt       <= '0;
      px        <= '0;
      disc      <= '0;
      ly        <= '0;
      ppu_vs    <= 1'b0;
      ppu_hs    <= 1'b0;
      ppu_de    <= 1'b0;
      ppu_color <= '0;
    end else begin
      state     <= state_d;
      sh_lo     <= lo_d;
      sh_hi     <= hi_d;
      cnt       <= cnt_d;
      px        <= px_d;
      disc      <= disc_d;
      ly        <= ly_d;
      ppu_vs    <= vs_d;
      ppu_hs    <= hs_d;
      ppu_de    <= de_d;
      ppu_color <= color_d;
    end
  end

endmodule

// File: tb/tb_ppu_pixel_out.sv
// Directed bench for ppu_pixel_out: full lines, fine scroll, stalls,
// frame abort and the 144-line limit.
module tb_ppu_pixel_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       line_start;
  logic [2:0] scx_fine;
  logic [7:0] bgp;
  logic [7:0] tile_lo;
  logic [7:0] tile_hi;
  logic       tile_valid;
  logic       tile_ready;
  logic       ppu_vs;
  logic       ppu_hs;
  logic       ppu_de;
  logic [1:0] ppu_color;
  logic       busy;
  logic [7:0] ly;

  int tests = 0;
  int fails = 0;

  logic [7:0] tlo [32];
  logic [7:0] thi [32];
  logic [1:0] first_col [3];

  always #5 clk = ~clk;

  ppu_pixel_out #(.LINE_PIXELS(160), .FRAME_LINES(144)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .line_start (line_start),
    .scx_fine   (scx_fine),
    .bgp        (bgp),
    .tile_lo    (tile_lo),
    .tile_hi    (tile_hi),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .ppu_vs     (ppu_vs),
    .ppu_hs     (ppu_hs),
    .ppu_de     (ppu_de),
    .ppu_color  (ppu_color),
    .busy       (busy),
    .ly         (ly)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Colour of the n-th emitted pixel of a line scrolled by scx.
  function automatic logic [1:0] exp_col(input int n, input int scx);
    int p, t, b;
    logic [1:0] ix;
    logic [7:0] pal;
    p   = n + scx;
    t   = p / 8;
    b   = 7 - (p % 8);
    ix  = {thi[t][b], tlo[t][b]};
    pal = bgp;
    return pal[2*ix +: 2];
  endfunction

  task automatic fill_tiles(input int mode);
    for (int i = 0; i < 32; i++) begin
      if (mode == 0) begin
        tlo[i] = 8'hFF;
        thi[i] = 8'h00;
      end else begin
        tlo[i] = 8'($urandom);
        thi[i] = 8'($urandom);
      end
    end
  endtask

  task automatic run_line(input int scx, input int gap_start, input int gap_len,
                          input int abort_at, input int exp_tiles, input int exp_gap_low);
    int  n_de = 0, n_tiles = 0, n_hs = 0, ti = 0, k = 0, gap_low = 0, ly0;
    bit  prev_de = 1'b0, done = 1'b0, aborted = 1'b0, acc;
    ly0        = int'(ly);
    line_start = 1'b1;
    scx_fine   = 3'(scx);
    tick();
    line_start = 1'b0;
    chk("busy_after_line_start", 32'(busy), 32'd1);
    while (!done && k < 400) begin
      tile_valid = !(k >= gap_start && k < gap_start + gap_len);
      tile_lo    = tlo[ti];
      tile_hi    = thi[ti];
      if (abort_at >= 0 && n_de == abort_at) frame_start = 1'b1;
      acc = tile_valid && tile_ready;
      tick();
      if (acc && ti < 31) ti++;
      if (acc) n_tiles++;
      if (frame_start) begin
        frame_start = 1'b0;
        tile_valid  = 1'b0;
        chk("abort_vs", 32'(ppu_vs), 32'd1);
        chk("abort_ly", 32'(ly), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_de", 32'(ppu_de), 32'd0);
        for (int c = 0; c < 20; c++) begin
          tick();
          chk("abort_no_hs", 32'(ppu_hs), 32'd0);
          chk("abort_no_de", 32'(ppu_de), 32'd0);
        end
        done    = 1'b1;
        aborted = 1'b1;
      end else begin
        if (ppu_de) begin
          chk("pixel_color", 32'(ppu_color), 32'(exp_col(n_de, scx)));
          if (n_de < 3) first_col[n_de] = ppu_color;
          n_de++;
        end else if (n_de > 0 && n_de < 160) begin
          gap_low++;
        end
        if (ppu_hs) begin
          n_hs++;
          chk("hs_after_last_de", 32'(prev_de), 32'd1);
          chk("hs_de_low", 32'(ppu_de), 32'd0);
          done = 1'b1;
        end
        prev_de = ppu_de;
      end
      k++;
    end
    tile_valid = 1'b0;
    if (!aborted) begin
      chk("de_count", 32'(n_de), 32'd160);
      chk("tiles_accepted", 32'(n_tiles), 32'(exp_tiles));
      chk("hs_count", 32'(n_hs), 32'd1);
      chk("mid_line_de_gaps", 32'(gap_low), 32'(exp_gap_low));
      chk("ly_incr", 32'(ly), 32'(ly0 + 1));
      chk("busy_after_line", 32'(busy), 32'd0);
      tick();
      chk("hs_one_cycle", 32'(ppu_hs), 32'd0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    scx_fine    = 3'd0;
    bgp         = 8'hE4;
    tile_lo     = 8'h00;
    tile_hi     = 8'h00;
    tile_valid  = 1'b0;
    repeat (3) tick();
    chk("rst_vs", 32'(ppu_vs), 32'd0);
    chk("rst_hs", 32'(ppu_hs), 32'd0);
    chk("rst_de", 32'(ppu_de), 32'd0);
    chk("rst_color", 32'(ppu_color), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ly", 32'(ly), 32'd0);
    chk("rst_ready", 32'(tile_ready), 32'd0);
    rst = 1'b0;
    tick();

    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("vs_pulse", 32'(ppu_vs), 32'd1);
    chk("vs_ly", 32'(ly), 32'd0);
    chk("vs_de", 32'(ppu_de), 32'd0);
    tick();
    chk("vs_single", 32'(ppu_vs), 32'd0);

    // Line 0: solid index 1 through E4 gives shade 01, 20 tiles.
    fill_tiles(0);
    run_line(0, 1000, 0, -1, 20, 0);
    chk("solid_first_color", 32'(first_col[0]), 32'd1);

    // Line 1: scroll 3; pixels 3..5 of AA/CC are indices 00,11,10.
    fill_tiles(1);
    tlo[0] = 8'b1010_1010;
    thi[0] = 8'b1100_1100;
    run_line(3, 1000, 0, -1, 21, 0);
    chk("scx_first0", 32'(first_col[0]), 32'd0);
    chk("scx_first1", 32'(first_col[1]), 32'd3);
    chk("scx_first2", 32'(first_col[2]), 32'd2);

    // Line 2: reversed palette, tile_valid low for 5 cycles when tile 5 is due.
    bgp = 8'h1B;
    fill_tiles(1);
    run_line(0, 40, 5, -1, 20, 5);

    for (int l = 3; l < 10; l++) begin
      bgp = 8'($urandom);
      fill_tiles(1);
      run_line(l % 8, 1000, 0, -1, (l % 8 == 0) ? 20 : 21, 0);
    end
    chk("ly_before_abort", 32'(ly), 32'd10);
    fill_tiles(1);
    run_line(0, 1000, 0, 80, 0, 0);
    chk("ly_after_abort", 32'(ly), 32'd0);
    fill_tiles(1);
    run_line(5, 1000, 0, -1, 21, 0);

    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("vs_frame2", 32'(ppu_vs), 32'd1);
    for (int l = 0; l < 144; l++) begin
      bgp = 8'(l * 37 + 5);
      fill_tiles(1);
      run_line(l % 8, 1000, 0, -1, (l % 8 == 0) ? 20 : 21, 0);
    end
    chk("ly_at_limit", 32'(ly), 32'd144);
    line_start = 1'b1;
    tile_valid = 1'b1;
    tick();
    line_start = 1'b0;
    chk("line145_busy", 32'(busy), 32'd0);
    chk("line145_ready", 32'(tile_ready), 32'd0);
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("line145_no_de", 32'(ppu_de), 32'd0);
      chk("line145_no_hs", 32'(ppu_hs), 32'd0);
    end
    chk("line145_ly", 32'(ly), 32'd144);
    tile_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
